// File: rtl/quotient_bcd_rx_if.sv
// Serial quotient frame in, one-cycle binary/BCD result out.
// The receiver uses the slave modport; the frame source/result consumer uses master.
interface quotient_bcd_rx_if #(
  parameter int NBITS   = 10,
  parameter int NDIGITS = 4
) ();
  // in_valid is a frame strobe held high for every bit of a frame, MSB first;
  // in_data is don't-care while in_valid=0. There is no ready: the receiver
  // always accepts. out_valid is a single-cycle pulse that qualifies out_bin,
  // out_bcd, out_err and out_div0, which read 0 whenever out_valid=0.
  logic                 in_valid;
  logic                 in_data;
  logic                 out_valid;
  logic [NBITS-1:0]     out_bin;
  logic [4*NDIGITS-1:0] out_bcd;
  logic                 out_err;
  logic                 out_div0;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_bin, out_bcd, out_err, out_div0
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_bin, out_bcd, out_err, out_div0
  );
endinterface

// File: rtl/quotient_bcd_rx.sv
// Rebuilds the serial quotient and converts it to packed BCD bit by bit.
// Optional QUOTIENT_DIV0_MARK_EN: all-ones quotient reported as div0 with blank BCD.
module quotient_bcd_rx #(
  parameter int NBITS   = 10,
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  quotient_bcd_rx_if.slave     bus,
  output logic [1:0]           fsm_state
);

  localparam int CW = $clog2(NBITS + 1);
  localparam int BW = 4 * NDIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [NBITS-1:0]  bin_sr;
  logic [BW-1:0]     bcd_sr;
  logic              ovf;

  logic              out_valid_r;
  logic [NBITS-1:0]  out_bin_r;
  logic [BW-1:0]     out_bcd_r;
  logic              out_err_r;
  logic              out_div0_r;

  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_step;
  logic [NBITS-1:0]  bin_step;
  logic [BW-1:0]     bcd_first;
  logic [NBITS-1:0]  bin_first;
  logic              frame_ok;
  logic              all_ones;

  // Correct every digit that would exceed 9 after doubling, then shift the
  // new bit into both the BCD accumulator and the binary accumulator.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < NDIGITS; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
      end
    end
    bcd_step  = (bcd_adj << 1) | {{(BW-1){1'b0}}, bus.in_data};
    bin_step  = (bin_sr << 1)  | {{(NBITS-1){1'b0}}, bus.in_data};
    bcd_first = {{(BW-1){1'b0}}, bus.in_data};
    bin_first = {{(NBITS-1){1'b0}}, bus.in_data};
    frame_ok  = (count == CW'(NBITS)) && !ovf;
    all_ones  = (bin_sr == {NBITS{1'b1}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      bin_sr      <= '0;
      bcd_sr      <= '0;
      ovf         <= 1'b0;
      out_valid_r <= 1'b0;
      out_bin_r   <= '0;
      out_bcd_r   <= '0;
      out_err_r   <= 1'b0;
      out_div0_r  <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      out_bin_r   <= '0;
      out_bcd_r   <= '0;
      out_err_r   <= 1'b0;
      out_div0_r  <= 1'b0;
      case (state)
        IDLE, OUT: begin
          // OUT accepts a new frame directly so back-to-back frames need no gap.
          if (bus.in_valid) begin
            bin_sr <= bin_first;
            bcd_sr <= bcd_first;
            count  <= CW'(1);
            ovf    <= 1'b0;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          if (bus.in_valid) begin
            if (count < CW'(NBITS)) begin
              bin_sr <= bin_step;
              bcd_sr <= bcd_step;
              count  <= count + CW'(1);
            end else begin
              ovf    <= 1'b1;
            end
          end else begin
            out_valid_r <= 1'b1;
            state       <= OUT;
            if (frame_ok) begin
              out_bin_r <= bin_sr;
`ifdef QUOTIENT_DIV0_MARK_EN
              if (all_ones) begin
                out_bcd_r  <= {BW{1'b1}};
                out_div0_r <= 1'b1;
              end else begin
                out_bcd_r  <= bcd_sr;
              end
`else
              out_bcd_r  <= bcd_sr;
              out_div0_r <= all_ones & 1'b0;
`endif
            end else begin
              out_err_r <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_bin   = out_bin_r;
  assign bus.out_bcd   = out_bcd_r;
  assign bus.out_err   = out_err_r;
  assign bus.out_div0  = out_div0_r;
  assign fsm_state     = state;

endmodule

// File: tb/tb_quotient_bcd_rx.sv
// Directed bench for quotient_bcd_rx: per-cycle model compare plus literal checks.
module tb_quotient_bcd_rx;
  localparam int NBITS   = 10;
  localparam int NDIGITS = 4;
  localparam int BW      = 4 * NDIGITS;

  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;

  quotient_bcd_rx_if #(.NBITS(NBITS), .NDIGITS(NDIGITS)) ifc ();

  quotient_bcd_rx #(.NBITS(NBITS), .NDIGITS(NDIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .fsm_state (fsm_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  bit              collecting = 1'b0;
  bit              bit_q[$];
  logic            exp_valid = 1'b0;
  logic [NBITS-1:0] exp_bin  = '0;
  logic [BW-1:0]   exp_bcd   = '0;
  logic            exp_err   = 1'b0;
  logic            exp_div0  = 1'b0;

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    r = '0;
    for (int d = 0; d < NDIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    int val;
    exp_valid = 1'b0;
    exp_bin   = '0;
    exp_bcd   = '0;
    exp_err   = 1'b0;
    exp_div0  = 1'b0;
    if (rst) begin
      collecting = 1'b0;
      bit_q.delete();
    end else if (ifc.in_valid) begin
      collecting = 1'b1;
      bit_q.push_back(ifc.in_data);
    end else if (collecting) begin
      collecting = 1'b0;
      exp_valid  = 1'b1;
      if (bit_q.size() == NBITS) begin
        val = 0;
        foreach (bit_q[i]) val = val * 2 + int'(bit_q[i]);
        exp_bin = NBITS'(val);
        exp_bcd = to_bcd(val);
`ifdef QUOTIENT_DIV0_MARK_EN
        if (val == (1 << NBITS) - 1) begin
          exp_bcd  = '1;
          exp_div0 = 1'b1;
        end
`endif
      end else begin
        exp_err = 1'b1;
      end
      bit_q.delete();
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [BW-1:0]    pulse_bcd_q[$];
  logic [NBITS-1:0] last_bin  = '0;
  logic [BW-1:0]    last_bcd  = '0;
  logic             last_err  = 1'b0;
  logic             last_div0 = 1'b0;

  always @(negedge clk) begin
    n_cmp++;
    if (ifc.out_valid !== exp_valid || ifc.out_bin !== exp_bin ||
        ifc.out_bcd !== exp_bcd || ifc.out_err !== exp_err ||
        ifc.out_div0 !== exp_div0) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t actual v=%b bin=%0d bcd=%h err=%b div0=%b required v=%b bin=%0d bcd=%h err=%b div0=%b",
               $time, ifc.out_valid, ifc.out_bin, ifc.out_bcd, ifc.out_err, ifc.out_div0,
               exp_valid, exp_bin, exp_bcd, exp_err, exp_div0);
    end
    if (ifc.out_valid === 1'b1) begin
      pulse_bcd_q.push_back(ifc.out_bcd);
      last_bin  = ifc.out_bin;
      last_bcd  = ifc.out_bcd;
      last_err  = ifc.out_err;
      last_div0 = ifc.out_div0;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ifc.in_valid = 1'b0;
      ifc.in_data  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  // Drives n bits MSB first, then one in_valid=0 cycle; returns 1ns after
  // the edge that sampled in_valid=0, i.e. inside the result pulse.
  task automatic send_frame(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = bits[i];
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    ifc.in_data  = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  int base;

  initial begin
    rst          = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 1'b0;
    #1;
    check("reset_valid", 32'(ifc.out_valid), 0);
    check("reset_bin",   32'(ifc.out_bin),   0);
    check("reset_bcd",   32'(ifc.out_bcd),   0);
    check("reset_err",   32'(ifc.out_err),   0);
    check("reset_div0",  32'(ifc.out_div0),  0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Reset mid-frame: partial frame must never be reported.
    base = pulse_bcd_q.size();
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 1'(i % 2);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(ifc.out_valid), 0);
    check("midrst_bcd",   32'(ifc.out_bcd),   0);
    ifc.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    check("midrst_no_pulse", 32'(pulse_bcd_q.size() - base), 0);

    // 123
    send_frame(16'b0001111011, 10);
    idle(2);
    check("f123_bin", 32'(last_bin), 123);
    check("f123_bcd", 32'(last_bcd), 32'h0123);
    check("f123_err", 32'(last_err), 0);

    // 999 with explicit timing checks
    send_frame(16'b1111100111, 10);
    check("f999_pulse_on",  32'(ifc.out_valid), 1);
    check("f999_bcd",       32'(ifc.out_bcd),   32'h0999);
    @(posedge clk); #1;
    check("f999_pulse_off", 32'(ifc.out_valid), 0);
    check("f999_bcd_off",   32'(ifc.out_bcd),   0);
    idle(1);

    // Asynchronous reset during a result pulse clears outputs at once.
    send_frame(16'b0000101101, 10);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(ifc.out_valid), 0);
    check("async_rst_bin",   32'(ifc.out_bin),   0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // All ones
    send_frame(16'b1111111111, 10);
    idle(2);
    check("f1023_bin", 32'(last_bin), 1023);
`ifdef QUOTIENT_DIV0_MARK_EN
    check("f1023_bcd",  32'(last_bcd),  32'hFFFF);
    check("f1023_div0", 32'(last_div0), 1);
`else
    check("f1023_bcd",  32'(last_bcd),  32'h1023);
    check("f1023_div0", 32'(last_div0), 0);
`endif

    // Short frame, then zero frame
    send_frame(16'b1010101, 7);
    idle(2);
    check("short_err", 32'(last_err), 1);
    check("short_bin", 32'(last_bin), 0);
    check("short_bcd", 32'(last_bcd), 0);
    send_frame(16'b0, 10);
    idle(2);
    check("zero_bcd", 32'(last_bcd), 0);
    check("zero_err", 32'(last_err), 0);

    // Long frame
    send_frame(16'b101010101010, 12);
    idle(2);
    check("long_err", 32'(last_err), 1);
    check("long_bcd", 32'(last_bcd), 0);

    // Back-to-back 500 then 7, new frame starts in the pulse cycle
    base = pulse_bcd_q.size();
    send_frame(16'd500, 10);
    send_frame(16'd7, 10);
    idle(3);
    check("b2b_count", 32'(pulse_bcd_q.size() - base), 2);
    if (pulse_bcd_q.size() - base == 2) begin
      check("b2b_first",  32'(pulse_bcd_q[base]),     32'h0500);
      check("b2b_second", 32'(pulse_bcd_q[base + 1]), 32'h0007);
    end
    check("b2b_last_bin", 32'(last_bin), 7);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
